uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; next generation of the fixed 8N1 transmitter in the serial TX path. Supports 5..MAX_DATA_BITS data bits, none/even/odd/mark parity, 1 or 2 stop bits, and line break generation. It uses a valid/ready handshake with a one-entry holding register, so frames run back-to-back with no idle bit between them. Bit timing comes from an external baud_tick strobe, one pulse per bit period.

Parameters:
MAX_DATA_BITS, 9, widest supported data field; legal range 5..9.
LEN_W, 4, width of cfg_data_len.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk strobe per bit period
tx_data  input  MAX_DATA_BITS  payload; bits at and above the configured length are ignored
tx_valid  input  1  payload and config valid
tx_ready  output  1  holding register empty; equals ~hold_valid
cfg_data_len  input  LEN_W  data bits per frame; below 5 treated as 5, above MAX_DATA_BITS treated as MAX_DATA_BITS
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 mark (parity bit = 1)
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits
tx_break  input  1  level request to hold the line low
tx_busy  output  1  high whenever state != IDLE
frame_done  output  1  one-clk pulse at the end of each data frame's final stop bit
tx_out  output  1  serial line; idles high

Behaviour:
- Reset (async, immediate, also mid-frame): tx_out=1, tx_busy=0, frame_done=0, hold_valid=0 (so tx_ready=1), state=IDLE, all counters 0.
- Handshake: accept on any clk where tx_valid && tx_ready, regardless of baud_tick. On accept, latch tx_data, clamped length, parity mode and stop2 into the holding register; config travels with its data. Later config changes do not affect a held or in-flight frame.
- State and output updates happen only on clk cycles with baud_tick=1, except handshake acceptance and frame_done deassertion.
- Each state names the bit currently on tx_out.
- State machine transitions (on baud_tick=1):
  - IDLE:
    - tx_break=1: drive 0, go to BREAK (break takes priority over pending data).
    - Else if hold_valid: drive 0, go to START; move hold into shift register; clear hold_valid.
    - Else tx_out stays 1.
  - START: drive shift[0], go to DATA, bit_cnt=0.
  - DATA:
    - If bit_cnt == len-1: go to PARITY and drive the parity bit if parity is enabled; otherwise go to STOP and drive 1 with stop_cnt=0.
    - Else drive the next bit (LSB first) and increment bit_cnt.
  - PARITY: drive 1, go to STOP, stop_cnt=0.
  - STOP:
    - If stop2 && stop_cnt==0: stop_cnt=1 and stay.
    - Else the frame ends. Pulse frame_done, unless this STOP followed a break. Then take the IDLE decision on this same tick: break, else the next frame's start bit (back-to-back), else IDLE with tx_out=1.
  - BREAK: while tx_break=1, hold 0. On a tick with tx_break=0: drive 1, go to STOP forced to two stop bits, with no frame_done.
- Parity is XOR over the len data bits only. Even: bit = XOR. Odd: bit = ~XOR. Mark: bit = 1.
- Frame length from start-bit tick to frame_done tick, in baud ticks: 1 + len + (parity?1:0) + stops.
- Simultaneous accept and hold-to-shift transfer on the same clk: not possible, because tx_ready=0 while hold is full; the new accept occurs on a later cycle.
- tx_busy stays high across back-to-back frames.

Decomposition:
- Package uart_pkg holds:
  - parity_t enum (NONE, EVEN, ODD, MARK);
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - constants MIN_DATA_BITS=5 and IDLE_LEVEL=1'b1.
- One sub-module, uart_parity_gen: combinational parity over a MAX_DATA_BITS vector masked by length and mode. It is reused by the future receiver.

Test Plan:
- 8N1, tx_data=0x55 -> tx_out per tick is 0,1,0,1,0,1,0,1,0,1; frame_done 10 ticks after the start tick; tx_busy falls on that tick.
- 7E2, tx_data=0x03 -> start, 1,1,0,0,0,0,0, parity 0, stop, stop; frame_done after 11 ticks. 7O1 with the same data gives parity 1.
- 9-bit mark parity, tx_data=0x1FF -> 9 ones, parity 1, stop; bit 8 is transmitted.
- Back-to-back: two accepts (0xA5 then 0x3C, second while the first is in flight) -> the second start bit occurs on the tick ending the first stop bit; no extra idle bit; tx_ready low from the second accept until its start tick.
- Break: tx_break asserted for 15 ticks while idle with a frame pending -> tx_out low for 15 ticks, then two stop ticks high, then the pending frame starts; no frame_done for the break.
- rst_n pulsed mid-DATA -> tx_out=1, tx_busy=0 and tx_ready=1 immediately (asynchronous); the next accepted frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART path.
// Used by the transmitter today and the receiver later.
package uart_pkg;

    localparam int   MIN_DATA_BITS = 5;
    localparam logic IDLE_LEVEL    = 1'b1;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10,
        MARK = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_t;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over the low len bits of a data word.
// Shared between the transmitter and the receiver.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int LEN_W         = 4
) (
    input  logic [MAX_DATA_BITS-1:0] data,
    input  logic [LEN_W-1:0]         len,
    input  parity_t                  mode,
    output logic                     enable,
    output logic                     parity_bit
);

    logic x;

    always_comb begin
        x = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (LEN_W'(i) < len) begin
                x = x ^ data[i];
            end
        end
    end

    always_comb begin
        enable     = (mode != NONE);
        parity_bit = 1'b0;
        unique case (mode)
            NONE: parity_bit = 1'b0;
            EVEN: parity_bit = x;
            ODD:  parity_bit = ~x;
            MARK: parity_bit = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a one-entry holding
// register so frames can run back-to-back.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int LEN_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     baud_tick,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [LEN_W-1:0]         cfg_data_len,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     tx_break,
    output logic                     tx_busy,
    output logic                     frame_done,
    output logic                     tx_out
);

    logic                     hold_valid;
    logic [MAX_DATA_BITS-1:0] hold_data;
    logic [LEN_W-1:0]         hold_len;
    parity_t                  hold_par;
    logic                     hold_stop2;

    logic [MAX_DATA_BITS-1:0] shift;
    logic [LEN_W-1:0]         cur_len;
    logic                     cur_par_en;
    logic                     cur_par_bit;
    logic                     cur_stop2;
    logic                     brk_stop;

    logic [LEN_W-1:0]         bit_cnt;
    logic                     stop_cnt;
    tx_state_t                state;

    logic [LEN_W-1:0]         len_clamped;
    logic                     par_en;
    logic                     par_bit;

    assign tx_ready = ~hold_valid;

    always_comb begin
        len_clamped = cfg_data_len;
        if (cfg_data_len < LEN_W'(MIN_DATA_BITS)) begin
            len_clamped = LEN_W'(MIN_DATA_BITS);
        end else if (cfg_data_len > LEN_W'(MAX_DATA_BITS)) begin
            len_clamped = LEN_W'(MAX_DATA_BITS);
        end
    end

    // Parity is resolved from the held frame and frozen at load.
    uart_parity_gen #(
        .MAX_DATA_BITS(MAX_DATA_BITS),
        .LEN_W        (LEN_W)
    ) u_parity (
        .data      (hold_data),
        .len       (hold_len),
        .mode      (hold_par),
        .enable    (par_en),
        .parity_bit(par_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            hold_len    <= '0;
            hold_par    <= NONE;
            hold_stop2  <= 1'b0;
            shift       <= '0;
            cur_len     <= '0;
            cur_par_en  <= 1'b0;
            cur_par_bit <= 1'b0;
            cur_stop2   <= 1'b0;
            brk_stop    <= 1'b0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            state       <= IDLE;
            tx_out      <= IDLE_LEVEL;
            tx_busy     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tx_valid && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= tx_data;
                hold_len   <= len_clamped;
                hold_par   <= parity_t'(cfg_parity);
                hold_stop2 <= cfg_stop2;
            end
            if (baud_tick) begin
                unique case (state)
                    IDLE: begin
                        if (tx_break) begin
                            state   <= BREAK;
                            tx_out  <= 1'b0;
                            tx_busy <= 1'b1;
                        end else if (hold_valid) begin
                            state       <= START;
                            tx_out      <= 1'b0;
                            tx_busy     <= 1'b1;
                            shift       <= hold_data;
                            cur_len     <= hold_len;
                            cur_par_en  <= par_en;
                            cur_par_bit <= par_bit;
                            cur_stop2   <= hold_stop2;
                            brk_stop    <= 1'b0;
                            hold_valid  <= 1'b0;
                        end else begin
                            tx_out  <= IDLE_LEVEL;
                            tx_busy <= 1'b0;
                        end
                    end
                    START: begin
                        state   <= DATA;
                        tx_out  <= shift[0];
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == cur_len - LEN_W'(1)) begin
                            if (cur_par_en) begin
                                state  <= PARITY;
                                tx_out <= cur_par_bit;
                            end else begin
                                state    <= STOP;
                                tx_out   <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            tx_out  <= shift[1];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + LEN_W'(1);
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        tx_out   <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (cur_stop2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            // Frame ends; the idle decision is taken on this tick.
                            frame_done <= ~brk_stop;
                            if (tx_break) begin
                                state   <= BREAK;
                                tx_out  <= 1'b0;
                                tx_busy <= 1'b1;
                            end else if (hold_valid) begin
                                state       <= START;
                                tx_out      <= 1'b0;
                                tx_busy     <= 1'b1;
                                shift       <= hold_data;
                                cur_len     <= hold_len;
                                cur_par_en  <= par_en;
                                cur_par_bit <= par_bit;
                                cur_stop2   <= hold_stop2;
                                brk_stop    <= 1'b0;
                                hold_valid  <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_out  <= IDLE_LEVEL;
                                tx_busy <= 1'b0;
                            end
                        end
                    end
                    BREAK: begin
                        if (!tx_break) begin
                            state     <= STOP;
                            tx_out    <= 1'b1;
                            stop_cnt  <= 1'b0;
                            cur_stop2 <= 1'b1;
                            brk_stop  <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx_out  <= IDLE_LEVEL;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected line bits are queued
// at stimulus time and popped by a monitor on every baud tick.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic [8:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] cfg_data_len;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx_break;
    logic       tx_busy;
    logic       frame_done;
    logic       tx_out;

    int         errors;
    int         checks;
    int         idx;
    logic       mon_en;
    logic [1:0] div;

    // {tx_out, frame_done, tx_busy} expected after each baud tick
    logic [2:0] exp_q[$];

    uart_tx_cfg #(
        .MAX_DATA_BITS(9),
        .LEN_W        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .cfg_data_len(cfg_data_len),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .tx_break    (tx_break),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .tx_out      (tx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        div       = 2'd0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            div       = div + 2'd1;
            baud_tick = (div == 2'd0);
        end
    end

    always @(posedge clk) begin : monitor
        logic       tk;
        logic [2:0] got;
        logic [2:0] want;
        tk = baud_tick;
        #1;
        if (tk && mon_en && rst_n && (tx_busy || frame_done)) begin
            got = {tx_out, frame_done, tx_busy};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit[%0d] got=%b want=none", idx, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL line_bit[%0d] got=%b want=%b", idx, got, want);
                end
            end
            idx++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push_str(input string s, input logic first_done);
        logic b;
        for (int i = 0; i < s.len(); i++) begin
            b = (s[i] == "1");
            exp_q.push_back({b, (i == 0) ? first_done : 1'b0, 1'b1});
        end
    endtask

    task automatic push_end();
        exp_q.push_back(3'b110);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic send(input logic [8:0] d, input logic [3:0] len,
                        input logic [1:0] par, input logic s2);
        for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready got=0 want=1");
        end
        tx_data      = d;
        cfg_data_len = len;
        cfg_parity   = par;
        cfg_stop2    = s2;
        tx_valid     = 1'b1;
        @(negedge clk);
        tx_valid     = 1'b0;
        tx_data      = ~d;
        cfg_data_len = 4'd6;
        cfg_parity   = ~par;
        cfg_stop2    = ~s2;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_busy) break;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        idx          = 0;
        mon_en       = 1'b1;
        rst_n        = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        cfg_data_len = 4'd8;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        tx_break     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        push_str("0101010101", 1'b0);
        push_end();
        send(9'h055, 4'd8, 2'b00, 1'b0);
        wait_drain("drain_8n1");

        push_str("01100000011", 1'b0);
        push_end();
        send(9'h003, 4'd7, 2'b01, 1'b1);
        wait_drain("drain_7e2");

        push_str("0110000011", 1'b0);
        push_end();
        send(9'h003, 4'd7, 2'b10, 1'b0);
        wait_drain("drain_7o1");

        push_str("011111111111", 1'b0);
        push_end();
        send(9'h1FF, 4'd9, 2'b11, 1'b0);
        wait_drain("drain_9m1");

        push_str("00101111", 1'b0);
        push_end();
        send(9'h03A, 4'd2, 2'b01, 1'b0);
        wait_drain("drain_len_low");

        push_str("00000000011", 1'b0);
        push_end();
        send(9'h100, 4'd15, 2'b00, 1'b0);
        wait_drain("drain_len_high");

        push_str("0101001011", 1'b0);
        push_str("0001111001", 1'b1);
        push_end();
        send(9'h0A5, 4'd8, 2'b00, 1'b0);
        send(9'h03C, 4'd8, 2'b00, 1'b0);
        chk("b2b_ready_low", tx_ready, 0);
        chk("b2b_busy", tx_busy, 1);
        wait_drain("drain_b2b");

        wait_ticks(1);
        @(negedge clk);
        tx_break = 1'b1;
        push_str("00000000000000011", 1'b0);
        push_str("0100000011", 1'b0);
        push_end();
        send(9'h081, 4'd8, 2'b00, 1'b0);
        wait_ticks(15);
        @(negedge clk);
        tx_break = 1'b0;
        wait_drain("drain_break");

        mon_en = 1'b0;
        send(9'h0F0, 4'd8, 2'b00, 1'b0);
        wait_ticks(4);
        @(negedge clk);
        chk("mid_busy", tx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx_out", tx_out, 1);
        chk("arst_busy", tx_busy, 0);
        chk("arst_ready", tx_ready, 1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_str("001011010111", 1'b0);
        push_end();
        send(9'h05A, 4'd8, 2'b10, 1'b1);
        wait_drain("drain_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
